nx_stream_arbiter: RTL and testbench
====================================

Name: nx_stream_arbiter

Overview:
- Round-robin arbiter merging INPUTS inbound node_message_t streams into one registered outbound stream.
- Sits directly upstream of the node's stream skid buffer: its outbound port feeds the skid inbound port.
- One-entry output register breaks the combinational valid/data path from the inbound streams to the skid.
- Grants rotate fairly across inputs, so no single inbound stream can starve another.

Parameters:
- INPUTS, 4, number of inbound streams; legal range 2..16.
- IDX_W, $clog2(INPUTS), width of the grant index; derived, never overridden.

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_inbound_data  input  INPUTS x node_message_t  inbound messages, one per stream.
- i_inbound_valid  input  INPUTS  per-stream valid.
- o_inbound_ready  output  INPUTS  per-stream ready; at most one bit high in any cycle.
- o_outbound_data  output  node_message_t  registered merged message.
- o_outbound_valid  output  1  registered outbound valid.
- i_outbound_ready  input  1  downstream (skid) ready.
- o_grant_idx  output  IDX_W  index of the stream that supplied the current outbound entry; for debug and statistics.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: o_outbound_valid=0, o_outbound_data=0, o_grant_idx=0, last-grant pointer last_q=INPUTS-1, so stream 0 has first priority after reset.
- Outbound register: valid_q, data_q and idx_q drive the outbound ports directly. There is no combinational inbound-to-outbound path.
- Accept condition: accept = !valid_q || i_outbound_ready.
- Pick: combinational search of i_inbound_valid starting at (last_q+1) mod INPUTS and wrapping through to last_q. The first set bit gives pick_idx and pick_vld.
- Ready: o_inbound_ready[k] = accept && pick_vld && (pick_idx==k). Ready depends on valid.
- Upstream rule: valid must never depend on ready. Once raised, valid and data must hold until the handshake completes.
- Transfer in (pick_vld && accept):
  - data_q <= i_inbound_data[pick_idx], idx_q <= pick_idx, valid_q <= 1, last_q <= pick_idx.
- Transfer out only (valid_q && i_outbound_ready && !pick_vld): valid_q <= 0. data_q, idx_q and last_q hold.
- Stall (valid_q && !i_outbound_ready): all state holds and every inbound ready bit is 0.
- Simultaneous out and in in the same cycle: the register is refilled. Sustained throughput is 1 message per cycle.
- Latency: a message accepted at edge N is presented on the outbound port from edge N until it is taken. That is 1 cycle from the input handshake.
- Fairness:
  - With all INPUTS streams continuously valid and the output always ready, grants cycle 0,1,..,INPUTS-1,0.
  - A stream waits at most INPUTS-1 grants.
- Pointer update: last_q updates only on a granted transfer. An idle cycle never advances it.
- Single requester: it is granted every accepting cycle, whatever the value of last_q.
- Wrap-around: with last_q=INPUTS-1, the search begins at index 0.
- Reset mid-operation: a held outbound entry is discarded (valid drops asynchronously). The inbound side must re-offer its messages.
- X-safety: i_inbound_data of a non-picked stream is never sampled.

Decomposition:
- node_message_t comes from the existing shared constants package, NXConstants.
- Add to NXConstants: NX_ARB_MAX_INPUTS=16. This is a localparam bound, checked by an elaboration-time assertion on INPUTS.
- Sub-module nx_rr_pick (purely combinational):
  - Inputs: a request vector and a last-grant index.
  - Outputs: pick_idx and pick_vld.
  - Implemented as a rotate, priority-encode, un-rotate.
  - Reusable by future arbiters.

Test Plan:
- Reset: hold i_rst_n=0 with all valids high -> o_outbound_valid=0 and o_inbound_ready=0000. After release, the first grant goes to stream 0 and o_grant_idx=0.
- All 4 streams valid continuously, downstream always ready, stream k carrying payload tagged k -> outbound tags 0,1,2,3,0,1,..., one per cycle with no bubbles.
- Only stream 2 valid for 5 cycles, downstream ready -> 5 consecutive grants to stream 2. Afterwards last_q=2 and the next all-valid grant goes to stream 3.
- Backpressure: output holds msg A and i_outbound_ready=0 for 3 cycles while streams 1 and 3 are valid -> o_outbound_data stays A, all readies are 0, and no inbound message is lost. When ready rises, stream 1 is granted in that same cycle.
- Streams 0 and 3 valid with last_q=3 -> stream 0 granted next, then stream 3. This checks wrap-around.
- Assert i_rst_n=0 asynchronously mid-cycle while valid_q=1 -> o_outbound_valid falls immediately, without waiting for a clock edge. The pointer returns to INPUTS-1.

Source files
------------

// File: rtl/NXConstants.sv
// Shared node-level constants and message types.
package NXConstants;

  // Upper bound on inbound streams for any stream arbiter instance.
  localparam int NX_ARB_MAX_INPUTS = 16;

  // Message carried on node-internal streams.
  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  kind;
    logic [31:0] payload;
  } node_message_t;

endpackage

// File: rtl/nx_rr_pick.sv
// Round-robin picker: first set request at or after (last+1) mod N, wrapping.
// Purely combinational: rotate, priority-encode, un-rotate.
module nx_rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_pick_idx,
  output logic             o_pick_vld
);

  // One extra bit so (last + offset) never overflows before the mod-N fold.
  localparam logic [IDX_W:0] NW  = (IDX_W+1)'(N);
  localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

  logic [N-1:0]   rot;
  logic [IDX_W:0] sum_r;
  logic [IDX_W:0] off;
  logic [IDX_W:0] sum_u;

  // Rotate requests so the search start position lands on bit 0.
  always_comb begin
    rot   = '0;
    sum_r = '0;
    for (int i = 0; i < N; i++) begin
      sum_r = {1'b0, i_last} + (IDX_W+1)'(i + 1);
      if (sum_r >= NW) sum_r = sum_r - NW;
      rot[i] = i_req[sum_r[IDX_W-1:0]];
    end
  end

  // Lowest set bit of the rotated vector is the winning offset.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDX_W+1)'(i);
    end
  end

  // Un-rotate the offset back into a stream index.
  always_comb begin
    sum_u = {1'b0, i_last} + off + ONE;
    if (sum_u >= NW) sum_u = sum_u - NW;
    o_pick_idx = sum_u[IDX_W-1:0];
    o_pick_vld = |i_req;
  end

endmodule

// File: rtl/nx_stream_arbiter.sv
// Round-robin merge of INPUTS message streams into one registered stream.
// The output register isolates the downstream skid buffer from inbound valid/data.
module nx_stream_arbiter
  import NXConstants::*;
#(
  parameter  int INPUTS = 4,
  localparam int IDX_W  = $clog2(INPUTS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  node_message_t [INPUTS-1:0] i_inbound_data,
  input  logic [INPUTS-1:0]          i_inbound_valid,
  output logic [INPUTS-1:0]          o_inbound_ready,
  output node_message_t              o_outbound_data,
  output logic                       o_outbound_valid,
  input  logic                       i_outbound_ready,
  output logic [IDX_W-1:0]           o_grant_idx
);

  if (INPUTS < 2 || INPUTS > NX_ARB_MAX_INPUTS) begin : g_bad_inputs
    $error("nx_stream_arbiter: INPUTS must be within 2..NX_ARB_MAX_INPUTS");
  end

  logic             valid_q;
  node_message_t    data_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             accept;

  nx_rr_pick #(.N(INPUTS)) u_pick (
    .i_req      (i_inbound_valid),
    .i_last     (last_q),
    .o_pick_idx (pick_idx),
    .o_pick_vld (pick_vld)
  );

  // Register can take a new entry when empty or being drained this cycle.
  // Held off during reset so no upstream handshake is lost while state is cleared.
  assign accept = (!valid_q || i_outbound_ready) && i_rst_n;

  // One-hot ready to the picked stream only.
  always_comb begin
    o_inbound_ready = '0;
    if (accept && pick_vld) o_inbound_ready[pick_idx] = 1'b1;
  end

  // Output register and grant pointer; pointer moves only on a granted transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(INPUTS - 1);
    end else if (accept) begin
      if (pick_vld) begin
        valid_q <= 1'b1;
        data_q  <= i_inbound_data[pick_idx];
        idx_q   <= pick_idx;
        last_q  <= pick_idx;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_outbound_valid = valid_q;
  assign o_outbound_data  = data_q;
  assign o_grant_idx      = idx_q;

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Directed bench for nx_stream_arbiter (INPUTS=4).
module tb_nx_stream_arbiter;
  import NXConstants::*;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  node_message_t [3:0]   i_inbound_data;
  logic [3:0]            i_inbound_valid;
  logic [3:0]            o_inbound_ready;
  node_message_t         o_outbound_data;
  logic                  o_outbound_valid;
  logic                  i_outbound_ready;
  logic [1:0]            o_grant_idx;

  int checks = 0;
  int errors = 0;

  nx_stream_arbiter #(.INPUTS(4)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_inbound_data   (i_inbound_data),
    .i_inbound_valid  (i_inbound_valid),
    .o_inbound_ready  (o_inbound_ready),
    .o_outbound_data  (o_outbound_data),
    .o_outbound_valid (o_outbound_valid),
    .i_outbound_ready (i_outbound_ready),
    .o_grant_idx      (o_grant_idx)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then sample 1ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Check the registered outbound entry.
  task automatic chk_out(input string tag, input logic [1:0] idx);
    chk({tag, "_valid"}, 64'(o_outbound_valid), 64'd1);
    chk({tag, "_idx"},   64'(o_grant_idx),      64'(idx));
    chk({tag, "_pay"},   64'(o_outbound_data.payload), 64'(32'hA0 + idx));
  endtask

  initial begin
    i_rst_n          = 1'b0;
    i_inbound_valid  = 4'b1111;
    i_outbound_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_inbound_data[k].src     = 4'(k);
      i_inbound_data[k].kind    = 4'h1;
      i_inbound_data[k].payload = 32'hA0 + 32'(k);
    end

    // Reset held with all streams valid.
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(o_outbound_valid), 64'd0);
    chk("rst_ready", 64'(o_inbound_ready),  64'd0);
    chk("rst_idx",   64'(o_grant_idx),      64'd0);
    chk("rst_data",  64'(o_outbound_data),  64'd0);

    // Release: all valid, downstream ready -> 0,1,2,3,0,1 with no bubbles.
    i_rst_n = 1'b1;
    #1;
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("rr_ready%0d", n), 64'(o_inbound_ready), 64'(4'b0001 << (n % 4)));
      step();
      chk_out($sformatf("rr%0d", n), 2'(n % 4));
    end

    // Single requester (stream 2) granted every cycle.
    i_inbound_valid = 4'b0100;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("solo_ready%0d", n), 64'(o_inbound_ready), 64'b0100);
      step();
      chk_out($sformatf("solo%0d", n), 2'd2);
    end
    // Pointer now 2: next all-valid grant goes to 3.
    i_inbound_valid = 4'b1111;
    #1;
    chk("after_solo_ready", 64'(o_inbound_ready), 64'b1000);
    step();
    chk_out("after_solo", 2'd3);

    // Wrap-around: pointer 3, streams 0 and 3 valid -> 0 then 3.
    i_inbound_valid = 4'b1001;
    #1;
    chk("wrap_ready0", 64'(o_inbound_ready), 64'b0001);
    step();
    chk_out("wrap0", 2'd0);
    #1;
    chk("wrap_ready1", 64'(o_inbound_ready), 64'b1000);
    step();
    chk_out("wrap1", 2'd3);

    // Backpressure: hold message from stream 3 for 3 cycles.
    i_outbound_ready = 1'b0;
    i_inbound_valid  = 4'b1010;
    #1;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("bp_ready%0d", n), 64'(o_inbound_ready), 64'd0);
      step();
      chk_out($sformatf("bp_hold%0d", n), 2'd3);
    end
    i_outbound_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(o_inbound_ready), 64'b0010);
    step();
    chk_out("bp_rel1", 2'd1);
    #1;
    chk("bp_next_ready", 64'(o_inbound_ready), 64'b1000);
    step();
    chk_out("bp_rel3", 2'd3);

    // Drain only: valid drops, index and pointer hold.
    i_inbound_valid = 4'b0000;
    #1;
    chk("idle_ready", 64'(o_inbound_ready), 64'd0);
    step();
    chk("idle_valid", 64'(o_outbound_valid), 64'd0);
    chk("idle_idx",   64'(o_grant_idx),      64'd3);
    i_inbound_valid = 4'b1111;
    #1;
    chk("post_idle_ready", 64'(o_inbound_ready), 64'b0001);
    step();
    chk_out("post_idle", 2'd0);

    // Asynchronous reset mid-cycle while holding an entry (pointer was 0).
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_outbound_valid), 64'd0);
    chk("arst_ready", 64'(o_inbound_ready),  64'd0);
    chk("arst_idx",   64'(o_grant_idx),      64'd0);
    #2;
    i_rst_n = 1'b1;
    #1;
    chk("arst_ptr_ready", 64'(o_inbound_ready), 64'b0001);
    step();
    chk_out("arst_first", 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
